// File: rtl/sommatore.sv
// sommatore: 16-bit unsigned adder with carry-in/carry-out and a registered result.
// The core is a two-level carry-lookahead adder: four 4-bit lookahead groups
// report group propagate/generate, and a second-level unit derives the group
// carries directly from those and r_in, so no carry ripples across groups.
module sommatore (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        r_in,
    output logic [15:0] s,
    output logic        r_out
);

    // Group propagate/generate of a 4-bit slice, returned as {G, P}.
    // Independent of the incoming carry, so it feeds the second level directly.
    function automatic logic [1:0] grp_pg(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] p;
        logic [3:0] g;
        logic       gp;
        logic       gg;
        p  = x ^ y;
        g  = x & y;
        gp = p[3] & p[2] & p[1] & p[0];
        gg = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        return {gg, gp};
    endfunction

    // Per-bit sums of a 4-bit slice given the slice carry-in; the internal
    // carries are fully expanded lookahead terms rather than a ripple.
    function automatic logic [3:0] grp_sum(input logic [3:0] x, input logic [3:0] y,
                                           input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return p ^ c;
    endfunction

    logic [3:0]  grp_p_s;
    logic [3:0]  grp_g_s;
    logic        c4_s;
    logic        c8_s;
    logic        c12_s;
    logic        c16_s;
    logic [15:0] sum_s;

    // First level: group propagate/generate for each 4-bit slice.
    always_comb begin
        grp_p_s = 4'b0000;
        grp_g_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] pg;
            pg = grp_pg(a[4*k +: 4], b[4*k +: 4]);
            grp_g_s[k] = pg[1];
            grp_p_s[k] = pg[0];
        end
    end

    // Second level: group carries straight from (P, G, r_in), two gate levels deep.
    always_comb begin
        c4_s  = grp_g_s[0] | (grp_p_s[0] & r_in);
        c8_s  = grp_g_s[1]
              | (grp_p_s[1] & grp_g_s[0])
              | (grp_p_s[1] & grp_p_s[0] & r_in);
        c12_s = grp_g_s[2]
              | (grp_p_s[2] & grp_g_s[1])
              | (grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
              | (grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & r_in);
        c16_s = grp_g_s[3]
              | (grp_p_s[3] & grp_g_s[2])
              | (grp_p_s[3] & grp_p_s[2] & grp_g_s[1])
              | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
              | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & r_in);
    end

    // Per-slice sums using the lookahead group carries.
    always_comb begin
        sum_s[3:0]   = grp_sum(a[3:0],   b[3:0],   r_in);
        sum_s[7:4]   = grp_sum(a[7:4],   b[7:4],   c4_s);
        sum_s[11:8]  = grp_sum(a[11:8],  b[11:8],  c8_s);
        sum_s[15:12] = grp_sum(a[15:12], b[15:12], c12_s);
    end

    // Result register: loads every edge, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s     <= 16'h0000;
            r_out <= 1'b0;
        end else begin
            s     <= sum_s;
            r_out <= c16_s;
        end
    end

endmodule

// File: tb/tb_sommatore.sv
// Self-checking bench for sommatore: directed vectors with literal expectations,
// a cycle-by-cycle comparison against an arithmetic reference, and random vectors.
module tb_sommatore;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        r_in = 1'b0;
    logic [15:0] s;
    logic        r_out;

    int n_cmp = 0;
    int n_err = 0;
    logic        chk_en = 1'b0;
    logic [16:0] exp_q = 17'd0;

    sommatore dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .r_in  (r_in),
        .s     (s),
        .r_out (r_out)
    );

    always #5 clk = ~clk;

    // Reference: the 17-bit sum of whatever is on the inputs at a rising edge,
    // forced to zero as soon as reset rises and while it is held.
    always @(posedge clk or posedge rst) begin
        if (rst)
            exp_q = 17'd0;
        else
            exp_q = {1'b0, a} + {1'b0, b} + {16'd0, r_in};
    end

    // Compare process: checks outputs against the reference mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({r_out, s} !== exp_q) begin
                n_err++;
                $display("FAIL model t=%0t: got r_out=%b s=%h required r_out=%b s=%h",
                         $time, r_out, s, exp_q[16], exp_q[15:0]);
            end
        end
    end

    task automatic lit(input string name, input logic [16:0] req);
        n_cmp++;
        if ({r_out, s} !== req) begin
            n_err++;
            $display("FAIL %s: got r_out=%b s=%h required r_out=%b s=%h",
                     name, r_out, s, req[16], req[15:0]);
        end
    endtask

    // Drive one vector away from the edge, then check one edge later.
    task automatic vec(input string name, input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, input logic [16:0] req);
        @(negedge clk);
        a = va; b = vb; r_in = vc;
        @(posedge clk);
        #1;
        lit(name, req);
    endtask

    initial begin
        // Reset held with all-ones inputs and the clock running.
        rst = 1'b1; a = 16'hFFFF; b = 16'hFFFF; r_in = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            lit("reset_hold", 17'h00000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        lit("reset_release", 17'h1FFFF);

        // Basic sums.
        vec("zero",      16'h0000, 16'h0000, 1'b0, 17'h0_0000);
        vec("basic1",    16'h5524, 16'h944A, 1'b0, 17'h0_E96E);
        vec("basic2",    16'h0002, 16'h944A, 1'b1, 17'h0_944D);
        // Carry-out.
        vec("carry1",    16'hD15A, 16'hA54B, 1'b1, 17'h1_76A6);
        vec("carry2",    16'hA93F, 16'hA54B, 1'b1, 17'h1_4E8B);
        // Carry through all four groups, then through three only.
        vec("full_prop", 16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
        vec("part_prop", 16'h0FFF, 16'h0000, 1'b1, 17'h0_1000);
        vec("grp_prop",  16'h00FF, 16'hFF00, 1'b1, 17'h1_0000);

        // Only the value present at the edge is sampled.
        @(negedge clk);
        a = 16'h1234; b = 16'h944A; r_in = 1'b1;
        #1 a = 16'hFFFF;
        #1 a = 16'h0002;
        @(posedge clk);
        #1;
        lit("sample_edge", 17'h0_944D);

        // Asynchronous reset mid-cycle clears before the next edge.
        @(negedge clk);
        a = 16'hD15A; b = 16'hA54B; r_in = 1'b1;
        @(posedge clk);
        #1;
        lit("pre_async", 17'h1_76A6);
        #1 rst = 1'b1;
        #1;
        lit("async_rst", 17'h00000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        lit("after_async", 17'h1_76A6);

        // Random vectors, checked by the compare process every cycle.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a    = 16'($urandom);
            b    = 16'($urandom);
            r_in = 1'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sommatore.md
# sommatore

16-bit binary adder with carry-in and carry-out, registered at the output. Computes `s`/`r_out` = `a + b + r_in` once per clock. It is the basic arithmetic primitive for wider datapaths: chain instances by feeding one's `r_out` into the next's `r_in` (each link adds one cycle).

## Interface
- No parameters; width is fixed at 16 bits.
- `clk`   in   1   rising-edge clock; the only clock.
- `rst`   in   1   reset, asynchronous, active-high; clears all outputs.
- `a`     in   16  addend A, unsigned.
- `b`     in   16  addend B, unsigned.
- `r_in`  in   1   carry-in ("riporto"), weight 1.
- `s`     out  16  registered sum, bits [15:0] of `a + b + r_in`.
- `r_out` out  1   registered carry-out, bit 16 of `a + b + r_in`.

## Operation
- Full 17-bit result R = `a + b + r_in`, range 0..131071.
  - `s` = R[15:0].
  - `r_out` = R[16].
- Unsigned arithmetic only. No signed overflow flag.
  - Two's-complement users derive overflow externally from the operand MSBs and `s[15]`.
- Combinational core is a two-level carry-lookahead adder:
  - four 4-bit CLA groups, each producing per-bit sums plus group propagate P and group generate G;
  - a second-level lookahead unit computes the group carries c4, c8, c12 and c16 from (P, G, `r_in`).
  - Ripple carry across all 16 bits is not permitted.
- Per-bit rules: p_i = a_i XOR b_i, g_i = a_i AND b_i, sum_i = p_i XOR c_i. Carry c0 = `r_in`.
- Result register: 17 flops holding {`r_out`, `s`}, loaded every rising `clk` edge.
  - No enable.
  - No input registers.
- Inputs `a`, `b` and `r_in` are sampled only at the rising edge. Changes between edges have no effect.
  - This includes multiple changes within one cycle.
- X or Z on any input: don't-care for the bench.

## Timing
- Latency: 1 cycle. Inputs present at rising edge N appear on `s`/`r_out` immediately after edge N.
- Throughput: one new addition per cycle; fully pipelined with no stalls.
- Reset:
  - `rst` = 1 forces `s` = 16'h0000 and `r_out` = 0 immediately, without waiting for a clock edge.
  - Outputs stay at those values while `rst` is high.
- First rising edge with `rst` low loads the sum of the inputs present at that edge.
- Reset asserted mid-stream discards the in-flight result. No partial value is held.
- Critical path: input flops upstream → CLA (about 4 gate levels + XOR) → result flops. Must close at the block's target clock with no multicycle constraint.
- Wrap-around: any result ≥ 65536 wraps `s` modulo 2^16 with `r_out` = 1.
  - Example: 16'hFFFF + 16'h0000 + 1 gives `s` = 16'h0000, `r_out` = 1.

## Test plan
- Reset: assert `rst` with `a` = 16'hFFFF, `b` = 16'hFFFF, `r_in` = 1 and clock running → `s` = 16'h0000 and `r_out` = 0 throughout. Release `rst` → after next edge, `s` = 16'hFFFF and `r_out` = 1.
- Basic sums, one per cycle, each checked one edge later:
  - 16'h0000 + 16'h0000 + 0 → `s` = 16'h0000, `r_out` = 0.
  - 16'h5524 + 16'h944A + 0 → `s` = 16'hE96E, `r_out` = 0.
  - 16'h0002 + 16'h944A + 1 → `s` = 16'h944D, `r_out` = 0.
- Carry-out: 16'hD15A + 16'hA54B + 1 → `s` = 16'h76A6, `r_out` = 1. Then 16'hA93F + 16'hA54B + 1 → `s` = 16'h4E8B, `r_out` = 1.
- Full carry propagation through all four groups: 16'hFFFF + 16'h0000 + 1 → `s` = 16'h0000, `r_out` = 1. Then 16'h0FFF + 16'h0000 + 1 → `s` = 16'h1000, `r_out` = 0.
- Sampling:
  - change `a` twice within one cycle (16'hFFFF, then 16'h0002) with `b` = 16'h944A, `r_in` = 1 → only the value present at the edge counts: `s` = 16'h944D.
  - assert `rst` asynchronously mid-cycle → outputs clear before the next edge.
- Random: 10,000 random (`a`, `b`, `r_in`) vectors checked one cycle later against the reference model {`r_out`, `s`} = `a` + `b` + `r_in`, with 17-bit compare.
